// File: rtl/gate_law_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_law_checker_pkg
//  Purpose  : Shared constants for the gate-law lab blocks. Holds the checker
//             state encoding (IDLE / RUN / DONE) and the law-select constants
//             used on the 'mode' input.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package gate_law_checker_pkg;

  // State encoding, 2 bits wide.
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = C_ST_IDLE,
    ST_RUN  = C_ST_RUN,
    ST_DONE = C_ST_DONE
  } state_t;

  // Law under test.
  // NAND form: expected = ~(&stim)  (~a | ~b)
  // NOR  form: expected = ~(|stim)  (~a & ~b)
  localparam logic MODE_NAND = 1'b0;
  localparam logic MODE_NOR  = 1'b1;

endpackage : gate_law_checker_pkg
`default_nettype wire

// File: rtl/gate_law_ref.sv
`default_nettype none
// ============================================================================
//  Module   : gate_law_ref
//  Purpose  : Combinational reference for the gate-law checker. Produces the
//             value the gate under test must return for the current vector.
//  Ports    : stim     in  N_IN  vector currently driven to the gate
//             mode     in  1     law select (MODE_NAND / MODE_NOR)
//             expected out 1     value the gate must return
//  Revision : 1.0  initial release
// ============================================================================
module gate_law_ref
  import gate_law_checker_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] stim,
  input  logic            mode,
  output logic            expected
);

  logic w_nand_form;
  logic w_nor_form;

  assign w_nand_form = ~(&stim);
  assign w_nor_form  = ~(|stim);
  assign expected    = (mode == MODE_NOR) ? w_nor_form : w_nand_form;

endmodule : gate_law_ref
`default_nettype wire

// File: rtl/gate_law_checker.sv
`default_nettype none
// ============================================================================
//  Module   : gate_law_checker
//  Purpose  : Sequential stimulus-and-check engine. Walks every input vector
//             of an N_IN-input gate, holds each for SETTLE+1 cycles, checks
//             the returned output against the selected De Morgan form and
//             reports pass / mismatch count / first failing vector.
//  Ports    : clk             in  1       system clock, rising edge
//             rst_n           in  1       asynchronous active-low reset
//             start           in  1       level; starts a run in IDLE/DONE
//             mode            in  1       law select, latched at start
//             dut_c           in  1       output of the gate under test
//             stim            out N_IN    vector driven to the gate
//             busy            out 1       run in progress
//             done            out 1       run finished (sticky)
//             pass            out 1       valid with done; err_cnt == 0
//             err_cnt         out N_IN+1  mismatch count (saturating)
//             first_err_vec   out N_IN    vector of the first mismatch
//             first_err_valid out 1       first_err_vec is captured
//  Revision : 1.0  initial release
// ============================================================================
module gate_law_checker
  import gate_law_checker_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1   // 0..15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic            dut_c,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam logic [3:0]      C_SETTLE   = SETTLE[3:0];
  localparam logic [3:0]      C_HOLD_ONE = 4'd1;
  localparam logic [N_IN-1:0] C_LAST_VEC = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] C_VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   C_ERR_MAX  = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN:0]   C_ERR_ONE  = {{N_IN{1'b0}}, 1'b1};

  state_t     r_state;
  logic [3:0] r_hold;
  logic       r_mode;

  logic w_expected;
  logic w_check;
  logic w_mismatch;

  gate_law_ref #(
    .N_IN (N_IN)
  ) u_ref (
    .stim     (stim),
    .mode     (r_mode),
    .expected (w_expected)
  );

  // The check edge is the last hold cycle of the current vector.
  assign w_check    = (r_state == ST_RUN) && (r_hold == C_SETTLE);
  assign w_mismatch = (dut_c != w_expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_hold          <= '0;
      r_mode          <= MODE_NAND;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state         <= ST_RUN;
            r_mode          <= mode;
            r_hold          <= '0;
            stim            <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end

        ST_RUN: begin
          // start and mode are deliberately not looked at here.
          if (w_check) begin
            if (w_mismatch) begin
              if (err_cnt != C_ERR_MAX) begin
                err_cnt <= err_cnt + C_ERR_ONE;
              end
              if (!first_err_valid) begin
                first_err_vec   <= stim;
                first_err_valid <= 1'b1;
              end
            end
            r_hold <= '0;
            if (stim == C_LAST_VEC) begin
              // pass must include the check happening on this same edge.
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              stim    <= '0;
              pass    <= (err_cnt == '0) && !w_mismatch;
            end else begin
              stim <= stim + C_VEC_ONE;
            end
          end else begin
            r_hold <= r_hold + C_HOLD_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : gate_law_checker
`default_nettype wire

// File: doc/gate_law_checker.md
# gate_law_checker

Sequential stimulus-and-check engine for the combinational gate exercises of this lab. It walks every input vector of an N-input gate under test, holds each vector long enough for the gate output to settle, and compares the returned output against the expected De Morgan form. It reports a pass flag, a mismatch count and the first failing vector. It sits on the board beside the gate module and drives its inputs from switches and a start button, with results shown on LEDs.

## Interface
- `N_IN`, default 2: number of gate inputs; vectors 0 … 2^N_IN−1.
- `SETTLE`, default 1: extra hold cycles per vector before checking. Allowed range is 0..15.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled each edge; begins a run in IDLE or DONE.
- `mode` in 1: law under test, latched at start. 0 expects ~(&stim) (NAND form, `~a|~b`). 1 expects ~(|stim) (NOR form, `~a&~b`).
- `dut_c` in 1: output returned by the gate under test.
- `stim` out N_IN: vector driven to the gate inputs (bit 0 = `a`, bit 1 = `b`).
- `busy` out 1: run in progress.
- `done` out 1: run finished; sticky until the next accepted start.
- `pass` out 1: valid when `done`; 1 iff `err_cnt` == 0.
- `err_cnt` out N_IN+1: number of mismatching vectors; saturates at 2^N_IN.
- `first_err_vec` out N_IN: stim value of the first mismatch.
- `first_err_valid` out 1: `first_err_vec` holds a captured value.

## Operation
- The state machine has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **Reset values:** `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_vec`=0, `first_err_valid`=0. Internal hold counter=0, latched mode=0.
- **IDLE or DONE with `start`=1 → RUN:**
  - Latch `mode`; set `stim`=0, `busy`=1, `done`=0, `pass`=0.
  - Clear `err_cnt`, `first_err_vec`, `first_err_valid` and the hold counter.
- **RUN:**
  - The hold counter counts 0..SETTLE.
  - When the counter equals SETTLE, that edge is the check edge for the current vector:
    - expected = ~(&stim) if mode=0, else ~(|stim);
    - if `dut_c` ≠ expected, increment `err_cnt`;
    - on the first mismatch, capture `stim` into `first_err_vec` and set `first_err_valid`=1.
  - On the same check edge, `stim` increments and the counter resets to 0.
- **Last vector:** the check of `stim` = 2^N_IN−1 moves to DONE. In the same edge: `busy`=0, `done`=1, `stim`=0, and `pass` is computed including that last check.
- **`start` during RUN** is ignored. It does not restart the run and does not change the latched mode.
- **Held `start`:** a level `start` held in DONE restarts a run every time DONE is entered, so the board button is edge-detected upstream.
- **`mode` changes during RUN** have no effect.
- **`stim` wrap** happens only through the DONE transition; `stim` never wraps to 0 inside RUN.
- **`rst_n` low mid-run:** all outputs go to reset values immediately (asynchronously). The run is abandoned.

## Timing
- Start accepted at edge k: vector i is driven from edge k + i·(SETTLE+1).
- Vector i is checked at edge k + (i+1)·(SETTLE+1).
- `done` rises at edge k + 2^N_IN·(SETTLE+1). With defaults this is k+8.
- `dut_c` is assumed combinational from `stim`, so it must settle within (SETTLE+1) clock periods.
- No output depends combinationally on any input; all outputs are registered.

## Structure
- **Shared lab package:** state encoding constants (IDLE/RUN/DONE) and the mode constants (MODE_NAND=0, MODE_NOR=1).
- **Sub-module `gate_law_ref`:** a small combinational sub-module, used only inside this block, that computes the expected value from `stim` and mode.
- **Registers and counters:** all live in the top module; there is no other hierarchy.

## Test plan
- **NAND gate, mode 0, defaults:** DUT = `~a|~b`, mode=0, 1-cycle `start` → `done`=1 at start edge+8, `pass`=1, `err_cnt`=0, `first_err_valid`=0.
- **Law mismatch:** same NAND DUT with mode=1 → mismatches at vectors 01 and 10, so `err_cnt`=2, `first_err_vec`=2'b01, `pass`=0.
- **Stuck-at-1 DUT:** DUT `dut_c`=1, mode=0 → mismatch only at vector 11, so `err_cnt`=1, `first_err_vec`=2'b11.
- **Extended settle:** SETTLE=3 with a NOR DUT, mode=1 → each `stim` value held 4 cycles, `done` at start edge+16, `pass`=1.
- **Start during RUN:** pulse `start` again at edge k+3 → no restart; `done` still at k+8, and `stim` sequence 0,1,2,3 is unchanged.
- **Reset mid-run:** assert `rst_n` low at edge k+5 → all outputs 0 immediately. After release, a new `start` runs a clean full sequence with `err_cnt` cleared.
